// File: rtl/scm_lut_ctrl.sv
// scm_lut_ctrl: sequencer in front of a latch-based C x K LUT store.
//   LOAD   : fills the store from a valid/ready stream (c-major, k-minor order),
//            then waits WriteLatency cycles so the last entry is committed.
//   ACTIVE : serves (c,k) lookups, one per cycle, response ReadLatency+1 later.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   load_start_i                     : pulse, start a full (re)load
//   in_valid_i/in_ready_o/in_data_i  : load stream
//   loaded_o / load_done_o           : LUT committed level / rising pulse
//   rd_valid_i/rd_ready_o/rd_c_i/rd_k_i : lookup request
//   rd_rvalid_o/rd_rdata_o           : lookup response
//   scm_raddr_o/scm_rdata_i          : store read port
//   scm_waddr_o/scm_wdata_o/scm_we_o : store write port
module scm_lut_ctrl #(
  parameter int unsigned C              = 32,
  parameter int unsigned K              = 16,
  parameter int unsigned DataTypeWidth  = 16,
  parameter int unsigned TotalAddrWidth = $clog2(C * K),
  parameter int unsigned WriteLatency   = 2,
  parameter int unsigned ReadLatency    = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      load_start_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [DataTypeWidth-1:0]  in_data_i,
  output logic                      loaded_o,
  output logic                      load_done_o,
  input  logic                      rd_valid_i,
  output logic                      rd_ready_o,
  input  logic [$clog2(C)-1:0]      rd_c_i,
  input  logic [$clog2(K)-1:0]      rd_k_i,
  output logic                      rd_rvalid_o,
  output logic [DataTypeWidth-1:0]  rd_rdata_o,
  output logic [TotalAddrWidth-1:0] scm_raddr_o,
  input  logic [DataTypeWidth-1:0]  scm_rdata_i,
  output logic [TotalAddrWidth-1:0] scm_waddr_o,
  output logic [DataTypeWidth-1:0]  scm_wdata_o,
  output logic                      scm_we_o
);

  localparam int unsigned DrainW = (WriteLatency > 1) ? $clog2(WriteLatency) : 1;
  localparam logic [TotalAddrWidth-1:0] LastAddr = TotalAddrWidth'(C * K - 1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(WriteLatency - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, ACTIVE} state_t;

  state_t                    state_q;
  logic [TotalAddrWidth-1:0] wr_cnt_q;
  logic [TotalAddrWidth-1:0] waddr_q;
  logic [TotalAddrWidth-1:0] raddr_q;
  logic [DataTypeWidth-1:0]  wdata_q;
  logic [DataTypeWidth-1:0]  rdata_q;
  logic [DrainW-1:0]         drain_cnt_q;
  logic [ReadLatency-1:0]    rd_pipe_q;
  logic                      rvalid_q;
  logic                      loaded_q;
  logic                      load_done_q;
  logic                      rd_idle;
  logic                      wr_beat;
  logic                      rd_accept;

  // Writes must not start while a read issued before a reload is still in flight.
  assign rd_idle    = (rd_pipe_q == '0) && !rvalid_q;
  assign in_ready_o = (state_q == LOAD) && rd_idle;
  assign wr_beat    = in_valid_i && in_ready_o;

  // A reload request wins over a lookup presented in the same cycle.
  assign rd_ready_o = (state_q == ACTIVE) && !load_start_i;
  assign rd_accept  = rd_valid_i && rd_ready_o;

  // Store ports follow the beat/request combinationally, hold last value otherwise.
  assign scm_we_o    = wr_beat;
  assign scm_waddr_o = wr_beat ? wr_cnt_q : waddr_q;
  assign scm_wdata_o = wr_beat ? in_data_i : wdata_q;
  assign scm_raddr_o = rd_accept ? {rd_c_i, rd_k_i} : raddr_q;

  assign loaded_o    = loaded_q;
  assign load_done_o = load_done_q;
  assign rd_rvalid_o = rvalid_q;
  assign rd_rdata_o  = rdata_q;

  // Phase sequencer and write-side state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wr_cnt_q    <= '0;
      drain_cnt_q <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      loaded_q    <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      if (wr_beat) begin
        waddr_q <= wr_cnt_q;
        wdata_q <= in_data_i;
      end
      case (state_q)
        IDLE: begin
          if (load_start_i) begin
            state_q  <= LOAD;
            wr_cnt_q <= '0;
          end
        end
        LOAD: begin
          if (wr_beat) begin
            wr_cnt_q <= wr_cnt_q + TotalAddrWidth'(1);
            if (wr_cnt_q == LastAddr) begin
              state_q     <= DRAIN;
              drain_cnt_q <= '0;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt_q == DrainLast) begin
            state_q     <= ACTIVE;
            drain_cnt_q <= '0;
            loaded_q    <= 1'b1;
            load_done_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + DrainW'(1);
          end
        end
        ACTIVE: begin
          if (load_start_i) begin
            state_q  <= LOAD;
            wr_cnt_q <= '0;
            loaded_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read pipeline: ReadLatency stages for the store, then the output register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_pipe_q <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      raddr_q   <= '0;
    end else begin
      if (rd_accept) raddr_q <= {rd_c_i, rd_k_i};
      rd_pipe_q[0] <= rd_accept;
      for (int unsigned i = 1; i < ReadLatency; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
      rvalid_q <= rd_pipe_q[ReadLatency-1];
      if (rd_pipe_q[ReadLatency-1]) rdata_q <= scm_rdata_i;
    end
  end

  // Protocol invariants.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!scm_we_o || state_q == LOAD);
      assert (!rd_accept || state_q == ACTIVE);
      assert ({1'b0, wr_cnt_q} <= {1'b0, LastAddr});
    end
  end

endmodule
